// File: rtl/pong_pkg.sv
// Shared pong definitions: controller state encoding, motion directions and the
// default screen and paddle geometry used by the ball, sprite and paddle logic.
package pong_pkg;

  localparam int unsigned DefHRes  = 640;
  localparam int unsigned DefVRes  = 480;
  localparam int unsigned DefBall  = 10;
  localparam int unsigned DefPadXl = 20;
  localparam int unsigned DefPadXr = 620;
  localparam int unsigned DefPadW  = 10;
  localparam int unsigned DefPadH  = 60;

  typedef enum logic [1:0] {
    StIdle,
    StServe,
    StPlay,
    StOver
  } ball_state_e;

  // DirPos is rightward on x and downward on y.
  typedef enum logic {
    DirNeg,
    DirPos
  } dir_e;

  function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/ball_step.sv
// One-frame ball motion: wall bounces, paddle hits and misses, computed combinationally.
// Every lower-bound compare is taken before any subtraction so coordinates never wrap.
module ball_step
  import pong_pkg::*;
#(
  parameter int unsigned H_RES  = DefHRes,
  parameter int unsigned V_RES  = DefVRes,
  parameter int unsigned BALL   = DefBall,
  parameter int unsigned SPEED  = 2,
  parameter int unsigned PAD_XL = DefPadXl,
  parameter int unsigned PAD_XR = DefPadXr,
  parameter int unsigned PAD_W  = DefPadW,
  parameter int unsigned PAD_H  = DefPadH
) (
  input  logic [10:0] x_i,
  input  logic [10:0] y_i,
  input  dir_e        dx_i,
  input  dir_e        dy_i,
  input  logic [10:0] lpad_y_i,
  input  logic [10:0] rpad_y_i,
  output logic [10:0] x_o,
  output logic [10:0] y_o,
  output dir_e        dx_o,
  output dir_e        dy_o,
  output logic        score_l_o,
  output logic        score_r_o
);

  localparam int unsigned Half = BALL / 2;

  localparam logic [10:0] Step      = 11'(SPEED);
  localparam logic [10:0] YTop      = 11'(Half);
  localparam logic [10:0] YTopLim   = 11'(Half + SPEED);
  localparam logic [10:0] YBot      = 11'(V_RES - 1 - Half);
  localparam logic [10:0] YBotLim   = 11'(V_RES - 1 - Half - SPEED);
  localparam logic [10:0] XlFace    = 11'(PAD_XL + PAD_W / 2 + Half);
  localparam logic [10:0] XlLim     = 11'(PAD_XL + PAD_W / 2 + Half + SPEED);
  localparam logic [10:0] XrFace    = 11'(PAD_XR - PAD_W / 2 - Half);
  localparam logic [10:0] XrLim     = 11'(PAD_XR - PAD_W / 2 - Half - SPEED);
  localparam logic [10:0] XlMissLim = 11'(Half + SPEED);
  localparam logic [10:0] XrMissLim = 11'(H_RES - 1 - Half - SPEED);
  localparam logic [10:0] Reach     = 11'(PAD_H / 2 + Half);

  logic l_near, r_near;

  assign l_near = (abs_diff(y_i, lpad_y_i) <= Reach);
  assign r_near = (abs_diff(y_i, rpad_y_i) <= Reach);

  always_comb begin
    x_o       = x_i;
    y_o       = y_i;
    dx_o      = dx_i;
    dy_o      = dy_i;
    score_l_o = 1'b0;
    score_r_o = 1'b0;

    if (dy_i == DirPos) begin
      if (y_i >= YBotLim) begin
        y_o  = YBot;
        dy_o = DirNeg;
      end else begin
        y_o = y_i + Step;
      end
    end else begin
      if (y_i <= YTopLim) begin
        y_o  = YTop;
        dy_o = DirPos;
      end else begin
        y_o = y_i - Step;
      end
    end

    // A paddle hit is checked before the miss so it wins when both apply.
    if (dx_i == DirNeg) begin
      if ((x_i <= XlLim) && l_near) begin
        x_o  = XlFace;
        dx_o = DirPos;
      end else if (x_i <= XlMissLim) begin
        score_r_o = 1'b1;
      end else begin
        x_o = x_i - Step;
      end
    end else begin
      if ((x_i >= XrLim) && r_near) begin
        x_o  = XrFace;
        dx_o = DirNeg;
      end else if (x_i >= XrMissLim) begin
        score_l_o = 1'b1;
      end else begin
        x_o = x_i + Step;
      end
    end
  end

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball controller: serve delay, per-frame ball motion, scoring and game-over.
// All outputs come straight from registers updated by the single FSM process.
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned H_RES        = DefHRes,
  parameter int unsigned V_RES        = DefVRes,
  parameter int unsigned BALL         = DefBall,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned PAD_XL       = DefPadXl,
  parameter int unsigned PAD_XR       = DefPadXr,
  parameter int unsigned PAD_W        = DefPadW,
  parameter int unsigned PAD_H        = DefPadH,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [10:0] lpad_y,
  input  logic [10:0] rpad_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic        ball_visible,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        point,
  output logic        game_over
);

  localparam int unsigned CntW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [CntW-1:0] CntLast  = CntW'(SERVE_FRAMES - 1);
  localparam logic [10:0]     CentreX  = 11'(H_RES / 2);
  localparam logic [10:0]     CentreY  = 11'(V_RES / 2);
  localparam logic [3:0]      WinScore = 4'(WIN_SCORE);

  ball_state_e     state_q;
  logic [10:0]     ball_x_q, ball_y_q;
  dir_e            dx_q, dy_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      score_l_q, score_r_q;
  logic            point_q, over_q, vis_q;

  logic [10:0] step_x, step_y;
  dir_e        step_dx, step_dy;
  logic        step_score_l, step_score_r;
  logic [3:0]  score_l_inc, score_r_inc;

  ball_step #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .BALL   (BALL),
    .SPEED  (SPEED),
    .PAD_XL (PAD_XL),
    .PAD_XR (PAD_XR),
    .PAD_W  (PAD_W),
    .PAD_H  (PAD_H)
  ) u_ball_step (
    .x_i       (ball_x_q),
    .y_i       (ball_y_q),
    .dx_i      (dx_q),
    .dy_i      (dy_q),
    .lpad_y_i  (lpad_y),
    .rpad_y_i  (rpad_y),
    .x_o       (step_x),
    .y_o       (step_y),
    .dx_o      (step_dx),
    .dy_o      (step_dy),
    .score_l_o (step_score_l),
    .score_r_o (step_score_r)
  );

  assign score_l_inc = (score_l_q >= WinScore) ? WinScore : score_l_q + 4'd1;
  assign score_r_inc = (score_r_q >= WinScore) ? WinScore : score_r_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ball_x_q  <= CentreX;
      ball_y_q  <= CentreY;
      dx_q      <= DirPos;
      dy_q      <= DirPos;
      cnt_q     <= '0;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      point_q   <= 1'b0;
      over_q    <= 1'b0;
      vis_q     <= 1'b0;
    end else begin
      point_q <= 1'b0;
      case (state_q)
        StIdle, StOver: begin
          // start outranks a coincident frame_tick; ticks are otherwise ignored here.
          if (start) begin
            state_q   <= StServe;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            cnt_q     <= '0;
            ball_x_q  <= CentreX;
            ball_y_q  <= CentreY;
            vis_q     <= 1'b1;
            over_q    <= 1'b0;
          end
        end
        StServe: begin
          if (frame_tick) begin
            if (cnt_q == CntLast) begin
              cnt_q   <= '0;
              state_q <= StPlay;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StPlay: begin
          if (frame_tick) begin
            dy_q <= step_dy;
            if (step_score_r) begin
              score_r_q <= score_r_inc;
              point_q   <= 1'b1;
              ball_x_q  <= CentreX;
              ball_y_q  <= CentreY;
              dx_q      <= DirNeg;
              cnt_q     <= '0;
              if (score_r_inc < WinScore) begin
                state_q <= StServe;
              end else begin
                state_q <= StOver;
                vis_q   <= 1'b0;
                over_q  <= 1'b1;
              end
            end else if (step_score_l) begin
              score_l_q <= score_l_inc;
              point_q   <= 1'b1;
              ball_x_q  <= CentreX;
              ball_y_q  <= CentreY;
              dx_q      <= DirPos;
              cnt_q     <= '0;
              if (score_l_inc < WinScore) begin
                state_q <= StServe;
              end else begin
                state_q <= StOver;
                vis_q   <= 1'b0;
                over_q  <= 1'b1;
              end
            end else begin
              ball_x_q <= step_x;
              ball_y_q <= step_y;
              dx_q     <= step_dx;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign ball_visible = vis_q;
  assign score_l      = score_l_q;
  assign score_r      = score_r_q;
  assign point        = point_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: directed game scenarios plus randomized play, all outputs
// compared every cycle against an integer model of the game rules.
module tb_ball_ctrl;

  localparam int HRes = 640;
  localparam int VRes = 480;
  localparam int Half = 5;
  localparam int Speed = 2;
  localparam int LFace = 20 + 5 + Half;
  localparam int RFace = 620 - 5 - Half;
  localparam int Reach = 30 + Half;
  localparam int ServeFrames = 60;
  localparam int Win = 9;

  localparam int MIdle = 0;
  localparam int MServe = 1;
  localparam int MPlay = 2;
  localparam int MOver = 3;

  logic        clk = 1'b0;
  logic        rst, frame_tick, start;
  logic [10:0] lpad_y, rpad_y;
  logic [10:0] ball_x, ball_y;
  logic        ball_visible, point, game_over;
  logic [3:0]  score_l, score_r;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: signed velocities, plain integer positions.
  int m_mode, mx, my, mvx, mvy, msl, msr, mcnt;
  bit mpoint;

  always #5 clk = ~clk;

  ball_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .start        (start),
    .lpad_y       (lpad_y),
    .rpad_y       (rpad_y),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .ball_visible (ball_visible),
    .score_l      (score_l),
    .score_r      (score_r),
    .point        (point),
    .game_over    (game_over)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic score_point(input bit right_scores, input int ny_dir);
    mpoint = 1'b1;
    mx = HRes / 2;
    my = VRes / 2;
    mvy = ny_dir;
    mcnt = 0;
    if (right_scores) begin
      msr = (msr + 1 > Win) ? Win : msr + 1;
      mvx = -Speed;
      m_mode = (msr < Win) ? MServe : MOver;
    end else begin
      msl = (msl + 1 > Win) ? Win : msl + 1;
      mvx = Speed;
      m_mode = (msl < Win) ? MServe : MOver;
    end
  endtask

  task automatic play_frame(input int lp, input int rp);
    int ny, nx, nvx, nvy;
    bit l_hit, r_hit;
    ny = my + mvy;
    nvy = mvy;
    if (ny <= Half) begin
      ny = Half;
      nvy = Speed;
    end else if (ny >= VRes - 1 - Half) begin
      ny = VRes - 1 - Half;
      nvy = -Speed;
    end
    nx = mx + mvx;
    nvx = mvx;
    l_hit = (mvx < 0) && (nx <= LFace) && ((my > lp ? my - lp : lp - my) <= Reach);
    r_hit = (mvx > 0) && (nx >= RFace) && ((my > rp ? my - rp : rp - my) <= Reach);
    if (l_hit) begin
      nx = LFace;
      nvx = Speed;
    end else if (r_hit) begin
      nx = RFace;
      nvx = -Speed;
    end else if (mvx < 0 && nx <= Half) begin
      score_point(1'b1, nvy);
      return;
    end else if (mvx > 0 && nx >= HRes - 1 - Half) begin
      score_point(1'b0, nvy);
      return;
    end
    mx = nx;
    my = ny;
    mvx = nvx;
    mvy = nvy;
  endtask

  task automatic model_step(input bit r, input bit s, input bit t, input int lp, input int rp);
    mpoint = 1'b0;
    if (r) begin
      m_mode = MIdle;
      mx = HRes / 2;
      my = VRes / 2;
      mvx = Speed;
      mvy = Speed;
      msl = 0;
      msr = 0;
      mcnt = 0;
      return;
    end
    case (m_mode)
      MIdle, MOver: if (s) begin
        m_mode = MServe;
        msl = 0;
        msr = 0;
        mcnt = 0;
        mx = HRes / 2;
        my = VRes / 2;
      end
      MServe: if (t) begin
        if (mcnt == ServeFrames - 1) m_mode = MPlay;
        else mcnt++;
      end
      MPlay: if (t) play_frame(lp, rp);
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("ball_x", int'(ball_x), mx);
    check("ball_y", int'(ball_y), my);
    check("visible", int'(ball_visible), int'(m_mode == MServe || m_mode == MPlay));
    check("score_l", int'(score_l), msl);
    check("score_r", int'(score_r), msr);
    check("point", int'(point), int'(mpoint));
    check("game_over", int'(game_over), int'(m_mode == MOver));
  endtask

  task automatic cycle(input bit r, input bit s, input bit t, input int lp, input int rp);
    rst = r;
    start = s;
    frame_tick = t;
    lpad_y = 11'(lp);
    rpad_y = 11'(rp);
    @(posedge clk);
    model_step(r, s, t, lp, rp);
    #1;
    compare_all();
  endtask

  task automatic serve_to_play();
    for (int i = 0; i < ServeFrames; i++) begin
      cycle(1'b0, (i == 10), 1'b1, 240, 240);
      cycle(1'b0, 1'b0, 1'b0, 240, 240);
    end
  endtask

  function automatic int clamp_pad(input int v);
    return (v < 0) ? 0 : ((v > VRes - 1) ? VRes - 1 : v);
  endfunction

  initial begin
    int npts, bound, lp, rp;
    bit r, s, t;
    rst = 1'b1;
    start = 1'b0;
    frame_tick = 1'b0;
    lpad_y = 11'd240;
    rpad_y = 11'd240;

    // Reset and idle behaviour.
    cycle(1'b1, 1'b0, 1'b0, 240, 240);
    cycle(1'b1, 1'b1, 1'b1, 240, 240);
    check("rst_x", int'(ball_x), 320);
    check("rst_y", int'(ball_y), 240);
    check("rst_vis", int'(ball_visible), 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 240, 240);
    check("idle_vis", int'(ball_visible), 0);

    // Start, full serve delay, then the first moving frame.
    cycle(1'b0, 1'b1, 1'b0, 240, 240);
    check("serve_vis", int'(ball_visible), 1);
    serve_to_play();
    cycle(1'b0, 1'b0, 1'b1, 240, 240);
    check("first_x", int'(ball_x), 322);
    check("first_y", int'(ball_y), 242);
    check("first_vis", int'(ball_visible), 1);

    // Right player tracks the ball, left paddle always out of reach: right wins 9-0.
    npts = 0;
    bound = 0;
    while (!(m_mode == MOver) && bound < 30000 && n_fail < 40) begin
      rp = my;
      lp = (my < 240) ? my + 100 : my - 100;
      cycle(1'b0, 1'b0, bound[0], lp, rp);
      if (point) npts++;
      bound++;
    end
    check("win_reached", int'(bound < 30000), 1);
    check("win_points", npts, 9);
    check("win_score_r", int'(score_r), 9);
    check("win_score_l", int'(score_l), 0);
    check("win_over", int'(game_over), 1);
    check("win_vis", int'(ball_visible), 0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 100, 100);
    check("over_hold", int'(score_r), 9);
    cycle(1'b0, 1'b1, 1'b1, 240, 240);
    check("restart_score", int'(score_r), 0);
    check("restart_over", int'(game_over), 0);
    check("restart_vis", int'(ball_visible), 1);

    // Randomized play with paddles that mostly track the ball.
    for (int i = 0; i < 30000 && n_fail < 40; i++) begin
      r = ($urandom_range(0, 2999) == 0);
      s = ($urandom_range(0, 149) == 0);
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) begin
        lp = clamp_pad(my + int'($urandom_range(0, 90)) - 45);
        rp = clamp_pad(my + int'($urandom_range(0, 90)) - 45);
      end else begin
        lp = int'($urandom_range(0, VRes - 1));
        rp = int'($urandom_range(0, VRes - 1));
      end
      cycle(r, s, t, lp, rp);
    end

    // Reset wins over a coincident tick in mid-play.
    cycle(1'b1, 1'b0, 1'b0, 240, 240);
    cycle(1'b0, 1'b1, 1'b0, 240, 240);
    serve_to_play();
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 1'b1, my, my);
    cycle(1'b1, 1'b1, 1'b1, 240, 240);
    check("midrst_x", int'(ball_x), 320);
    check("midrst_y", int'(ball_y), 240);
    check("midrst_vis", int'(ball_visible), 0);
    check("midrst_over", int'(game_over), 0);
    check("midrst_point", int'(point), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_ctrl.md
BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 SHALL have parameters: H_RES 640 (visible width px); V_RES 480 (visible height px); BALL 10 (ball side px, even); SPEED 2 (px per frame per axis); PAD_XL 20 (left paddle centre x); PAD_XR 620 (right paddle centre x); PAD_W 10 (paddle width); PAD_H 60 (paddle height); SERVE_FRAMES 60 (serve delay in frames); WIN_SCORE 9 (points to win).
REQ-002 SHALL have ports: clk in 1 (sole clock); rst in 1 (reset); frame_tick in 1 (one-cycle pulse per frame at vblank start); start in 1 (one-cycle start pulse); lpad_y in 11 (left paddle centre y); rpad_y in 11 (right paddle centre y); ball_x out 11 (ball centre x, feeds sprite sx); ball_y out 11 (ball centre y, feeds sprite sy); ball_visible out 1 (ball sprite enable); score_l out 4; score_r out 4; point out 1 (one-cycle pulse on score); game_over out 1.
REQ-003 SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 SHALL implement states IDLE, SERVE, PLAY, OVER.
REQ-005 IDLE: ball held at (H_RES/2, V_RES/2), ball_visible=0; start -> SERVE with scores cleared, serve counter 0.
REQ-006 SERVE: ball at centre, ball_visible=1; each frame_tick increments serve counter; frame_tick with counter = SERVE_FRAMES-1 -> PLAY.
REQ-007 PLAY: each frame_tick updates ball position the cycle after the tick (1-cycle latency); no change without frame_tick.
REQ-008 Position update, HALF=BALL/2: moving down -> y+SPEED; moving up -> y-SPEED; same for x; all 11-bit unsigned; every lower-bound test SHALL precede subtraction, so no underflow.
REQ-009 Top wall: moving up and y <= HALF+SPEED -> y'=HALF, dy flips to down; bottom: moving down and y >= V_RES-1-HALF-SPEED -> y'=V_RES-1-HALF, dy flips to up.
REQ-010 Left paddle: moving left, x <= PAD_XL+PAD_W/2+HALF+SPEED, |y - lpad_y| <= PAD_H/2+HALF -> x'=PAD_XL+PAD_W/2+HALF, dx flips right; right paddle mirrored with PAD_XR, rpad_y, x'=PAD_XR-PAD_W/2-HALF.
REQ-011 Miss: moving left with x <= HALF+SPEED and no paddle hit -> score_r+1; moving right with x >= H_RES-1-HALF-SPEED and no hit -> score_l+1.
REQ-012 Paddle hit SHALL take precedence over miss in the same frame; vertical and horizontal rules SHALL apply independently in the same frame (corner = both flips).
REQ-013 On a point: point=1 one cycle, ball recentred, dx toward the scoring player's opponent, dy kept; -> SERVE if new score < WIN_SCORE, else -> OVER.
REQ-014 OVER: game_over=1, ball_visible=0, frame_tick ignored, scores held; start -> SERVE with scores cleared.
REQ-015 start in SERVE or PLAY SHALL be ignored; start and frame_tick coincident in IDLE/OVER: start wins, tick ignored.
REQ-016 Scores SHALL saturate at WIN_SCORE, never wrap.

Reset
REQ-017 rst SHALL force: state IDLE, ball_x=H_RES/2 (320), ball_y=V_RES/2 (240), dx right, dy down, score_l=score_r=0, serve counter 0, point=0, game_over=0, ball_visible=0.
REQ-018 rst SHALL take priority over start and frame_tick in any state, including mid-PLAY; all outputs registered.

Structure
REQ-019 State encoding and default geometry constants (H_RES, V_RES, paddle x positions, BALL) SHALL live in a shared pong package, also used by the sprite and paddle logic.
REQ-020 Collision/next-position computation SHALL be one combinational sub-module, ball_step; the FSM, counter and score registers stay in ball_ctrl.

Verification
REQ-021 rst, start, 60 frame_ticks -> PLAY; next tick -> ball (322,242), visible=1.
REQ-022 PLAY, ball y=6 moving up, tick -> y=5, dy down; next tick -> y=7.
REQ-023 Ball x=32 moving left, y=240, lpad_y=270, tick -> x=30, dx right, no point; repeat with lpad_y=200 (|diff|=40>35) -> no flip.
REQ-024 Ball y=240 moving left, lpad_y=100, ticks until x<=7 -> score_r=1, point pulses once, SERVE, ball (320,240), dx left.
REQ-025 score_r=8, right scores -> score_r=9, game_over=1, visible=0; further ticks leave state; start -> SERVE, scores 0.
REQ-026 rst asserted mid-PLAY at ball (400,100) coincident with frame_tick -> next cycle all REQ-017 values.
